// File: rtl/instr_mem_responder.sv
// Instruction memory responder.
// Single-outstanding fetch port in front of a preloadable word memory. A granted
// request returns its word a fixed WAIT_STATES+1 cycles later. Misaligned or
// out-of-range fetches return a NOP with instr_err_o set.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   instr_req_i        - fetch request, held until granted
//   instr_addr_i       - fetch byte address
//   instr_gnt_o        - request accepted this cycle (combinational)
//   instr_rvalid_o     - response valid this cycle
//   instr_rdata_o      - fetched word (held between responses)
//   instr_err_o        - fetch error, qualified by instr_rvalid_o
//   load_we_i          - preload write enable (blocks new grants)
//   load_addr_i        - preload word index
//   load_wdata_i       - preload data
//   busy_o             - a transaction is pending
module instr_mem_responder #(
    parameter int unsigned           WORD_WIDTH  = 32,
    parameter int unsigned           MEM_DEPTH   = 1024,
    parameter int unsigned           WAIT_STATES = 1,
    parameter logic [WORD_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_req_i,
    input  logic [WORD_WIDTH-1:0]        instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [WORD_WIDTH-1:0]        instr_rdata_o,
    output logic                         instr_err_o,
    input  logic                         load_we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr_i,
    input  logic [WORD_WIDTH-1:0]        load_wdata_i,
    output logic                         busy_o
);

    localparam int unsigned           AW        = $clog2(MEM_DEPTH);
    localparam logic [WORD_WIDTH-1:0] DEPTH_W   = WORD_WIDTH'(MEM_DEPTH);
    localparam logic [WORD_WIDTH-1:0] NOP       = WORD_WIDTH'(32'h0000_0013);
    localparam logic [2:0]            WAIT_INIT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t                  state;
    logic [2:0]              wait_cnt;
    logic [WORD_WIDTH-1:0]   addr_lat;
    logic [WORD_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    gnt;
    logic [WORD_WIDTH-1:0]   fetch_addr;
    logic [WORD_WIDTH-1:0]   fetch_off;
    logic [AW-1:0]           fetch_idx;
    logic                    fetch_err;
    logic [WORD_WIDTH-1:0]   fetch_data;

    // A new request can be taken while idle or in the response cycle, which
    // gives one word per cycle when there are no wait states.
    assign gnt         = instr_req_i & ~load_we_i & ~rst &
                         ((state == StIdle) | (state == StResp));
    assign instr_gnt_o = gnt;
    assign busy_o      = (state != StIdle);

    // Lookup for the word captured on the edge entering the response cycle.
    // From WAIT the latched address is used; with zero wait states the fetch
    // is resolved straight from the incoming address in the grant cycle.
    always_comb begin
        fetch_addr = (state == StWait) ? addr_lat : instr_addr_i;
        fetch_off  = fetch_addr - BASE_ADDR;  // wraps for addresses below base
        fetch_idx  = fetch_off[AW+1:2];
        fetch_err  = (fetch_addr[1:0] != 2'b00) || ((fetch_off >> 2) >= DEPTH_W);
        fetch_data = fetch_err ? NOP : mem[fetch_idx];
    end

    // Preload port; memory is deliberately not reset. The read above sees the
    // pre-write contents, so a colliding write is read-before-write.
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem[load_addr_i] <= load_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            wait_cnt       <= 3'd0;
            addr_lat       <= '0;
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= '0;
            instr_err_o    <= 1'b0;
        end else begin
            instr_rvalid_o <= 1'b0;
            unique case (state)
                StIdle, StResp: begin
                    if (gnt) begin
                        addr_lat <= instr_addr_i;
                        wait_cnt <= WAIT_INIT;
                        if (WAIT_STATES == 0) begin
                            state          <= StResp;
                            instr_rvalid_o <= 1'b1;
                            instr_rdata_o  <= fetch_data;
                            instr_err_o    <= fetch_err;
                        end else begin
                            state <= StWait;
                        end
                    end else begin
                        state <= StIdle;
                    end
                end
                StWait: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        state          <= StResp;
                        instr_rvalid_o <= 1'b1;
                        instr_rdata_o  <= fetch_data;
                        instr_err_o    <= fetch_err;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: three instances with 0, 1 and 3 wait states
// sharing one clock and reset. Table-driven fetches, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_instr_mem_responder;

    localparam int          W     = 32;
    localparam int          DEPTH = 16;
    localparam int          NI    = 3;
    localparam logic [31:0] B     = 32'h0000_1000;

    function automatic int ws_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [NI];
    logic [31:0] addr   [NI];
    logic        we     [NI];
    logic [3:0]  laddr  [NI];
    logic [31:0] wdata  [NI];
    logic        gnt    [NI];
    logic        rvalid [NI];
    logic [31:0] rdata  [NI];
    logic        err    [NI];
    logic        busy   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        instr_mem_responder #(
            .WORD_WIDTH (W),
            .MEM_DEPTH  (DEPTH),
            .WAIT_STATES(ws_of(g)),
            .BASE_ADDR  (B)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .instr_req_i   (req[g]),
            .instr_addr_i  (addr[g]),
            .instr_gnt_o   (gnt[g]),
            .instr_rvalid_o(rvalid[g]),
            .instr_rdata_o (rdata[g]),
            .instr_err_o   (err[g]),
            .load_we_i     (we[g]),
            .load_addr_i   (laddr[g]),
            .load_wdata_i  (wdata[g]),
            .busy_o        (busy[g])
        );
    end

    int          n_checks;
    int          n_pass;
    logic [31:0] exp_mem [NI][DEPTH];

    // Transaction-level model state for the random phase.
    int          left    [NI];   // cycles until response, 0 = response now, -1 = none
    logic [31:0] paddr   [NI];
    logic [31:0] last_d  [NI];
    logic        last_e  [NI];
    logic        gprev   [NI];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {err, data} for a fetch of address a from instance k's memory.
    function automatic logic [32:0] resp_of(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - B;
        if (a[1:0] != 2'b00 || (off >> 2) >= 32'(DEPTH)) return {1'b1, 32'h0000_0013};
        return {1'b0, exp_mem[k][off[5:2]]};
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1:    return B + 32'($urandom_range(0, 15) * 4);
            2:       return B + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            3:       return B + 32'(64 + $urandom_range(0, 15) * 4);
            4:       return B - 32'($urandom_range(1, 8) * 4);
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    // Single fetch on instance k; lat counts cycles from grant to rvalid (-1 on timeout).
    task automatic fetch(input int k, input logic [31:0] a,
                         output logic [31:0] d, output logic e, output int lat);
        int n;
        req[k]  = 1'b1;
        addr[k] = a;
        n = 0;
        @(negedge clk);
        while (!gnt[k] && n < 10) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!gnt[k]) begin
            req[k] = 1'b0;
            d = 'x;
            e = 1'bx;
            lat = -1;
            tick();
            return;
        end
        tick();
        req[k] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rvalid[k] && lat < 12) begin
            tick();
            @(negedge clk);
            lat++;
        end
        d = rdata[k];
        e = err[k];
        if (!rvalid[k]) lat = -1;
        tick();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [8];
        logic [31:0] d;
        logic        e;
        int          lat;
        logic        seen;
        logic [32:0] r;
        logic        gexp;

        vecs[0] = '{B + 32'h00, 32'h0000_0011, 1'b0};
        vecs[1] = '{B + 32'h04, 32'h0000_0022, 1'b0};
        vecs[2] = '{B + 32'h3C, 32'h0000_0110, 1'b0};  // last valid word
        vecs[3] = '{B + 32'h02, 32'h0000_0013, 1'b1};  // misaligned
        vecs[4] = '{B + 32'h40, 32'h0000_0013, 1'b1};  // one past the end
        vecs[5] = '{B - 32'h04, 32'h0000_0013, 1'b1};  // below base wraps
        vecs[6] = '{B + 32'h0C, 32'h0000_0044, 1'b0};
        vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1};

        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        for (int k = 0; k < NI; k++) begin
            req[k] = 1'b1;  // grant must stay low during reset
            addr[k] = B;
            we[k] = 1'b0;
            laddr[k] = 4'd0;
            wdata[k] = 32'd0;
            left[k] = -1;
            last_d[k] = 32'd0;
            last_e[k] = 1'b0;
            gprev[k] = 1'b0;
        end
        tick();
        tick();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("reset_gnt", 64'(gnt[k]), 64'd0);
            check("reset_rvalid", 64'(rvalid[k]), 64'd0);
            check("reset_rdata", 64'(rdata[k]), 64'd0);
            check("reset_err", 64'(err[k]), 64'd0);
            check("reset_busy", 64'(busy[k]), 64'd0);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < NI; k++) req[k] = 1'b0;

        // Preload word i with 0x11*(i+1).
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < NI; k++) begin
                we[k] = 1'b1;
                laddr[k] = 4'(i);
                wdata[k] = 32'(17 * (i + 1));
                exp_mem[k][i] = 32'(17 * (i + 1));
            end
            tick();
        end
        for (int k = 0; k < NI; k++) we[k] = 1'b0;

        // Table of single fetches on every instance.
        for (int k = 0; k < NI; k++) begin
            for (int v = 0; v < 8; v++) begin
                fetch(k, vecs[v].addr, d, e, lat);
                check("table_rdata", 64'(d), 64'(vecs[v].data));
                check("table_err", 64'(e), 64'(vecs[v].err));
                check("table_latency", 64'(lat), 64'(ws_of(k) + 1));
            end
        end

        // Zero wait states: back-to-back grants and responses.
        req[0] = 1'b1;
        addr[0] = B;
        @(negedge clk);
        check("b2b_gnt0", 64'(gnt[0]), 64'd1);
        check("b2b_rv0", 64'(rvalid[0]), 64'd0);
        tick();
        addr[0] = B + 32'h4;
        @(negedge clk);
        check("b2b_gnt1", 64'(gnt[0]), 64'd1);
        check("b2b_rv1", 64'(rvalid[0]), 64'd1);
        check("b2b_d1", 64'(rdata[0]), 64'h11);
        tick();
        addr[0] = B + 32'h8;
        @(negedge clk);
        check("b2b_gnt2", 64'(gnt[0]), 64'd1);
        check("b2b_rv2", 64'(rvalid[0]), 64'd1);
        check("b2b_d2", 64'(rdata[0]), 64'h22);
        tick();
        req[0] = 1'b0;
        @(negedge clk);
        check("b2b_rv3", 64'(rvalid[0]), 64'd1);
        check("b2b_d3", 64'(rdata[0]), 64'h33);
        tick();
        @(negedge clk);
        check("b2b_rv_end", 64'(rvalid[0]), 64'd0);
        check("b2b_busy_end", 64'(busy[0]), 64'd0);
        tick();

        // Load write blocks the grant; the new word is then fetched.
        req[1] = 1'b1;
        addr[1] = B + 32'h14;
        we[1] = 1'b1;
        laddr[1] = 4'd5;
        wdata[1] = 32'hABCD_0005;
        @(negedge clk);
        check("load_blocks_gnt", 64'(gnt[1]), 64'd0);
        tick();
        we[1] = 1'b0;
        exp_mem[1][5] = 32'hABCD_0005;
        @(negedge clk);
        check("gnt_after_load", 64'(gnt[1]), 64'd1);
        tick();
        req[1] = 1'b0;
        @(negedge clk);
        check("load_rv_wait", 64'(rvalid[1]), 64'd0);
        tick();
        @(negedge clk);
        check("load_rv", 64'(rvalid[1]), 64'd1);
        check("load_new_data", 64'(rdata[1]), 64'hABCD_0005);
        tick();

        // Write to the word being read on the edge entering RESP: old data returned.
        req[1] = 1'b1;
        addr[1] = B + 32'h8;
        @(negedge clk);
        check("rbw_gnt", 64'(gnt[1]), 64'd1);
        tick();
        req[1] = 1'b0;
        we[1] = 1'b1;
        laddr[1] = 4'd2;
        wdata[1] = 32'h5555_0002;
        @(negedge clk);
        tick();
        we[1] = 1'b0;
        exp_mem[1][2] = 32'h5555_0002;
        @(negedge clk);
        check("rbw_rv", 64'(rvalid[1]), 64'd1);
        check("rbw_old_data", 64'(rdata[1]), 64'h33);
        tick();
        fetch(1, B + 32'h8, d, e, lat);
        check("rbw_new_data", 64'(d), 64'h5555_0002);

        // Reset one cycle after grant with three wait states: fetch is dropped.
        req[2] = 1'b1;
        addr[2] = B + 32'h4;
        @(negedge clk);
        check("rst_mid_gnt", 64'(gnt[2]), 64'd1);
        tick();
        req[2] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | rvalid[2];
            if (i == 0) check("rst_mid_busy", 64'(busy[2]), 64'd0);
            tick();
        end
        check("rst_mid_no_rvalid", 64'(seen), 64'd0);
        fetch(2, B + 32'h4, d, e, lat);
        check("rst_mem_kept", 64'(d), 64'h22);
        check("rst_mem_lat", 64'(lat), 64'd4);

        // Randomized traffic against the model, starting from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < NI; k++) begin
                if (!(req[k] && !gprev[k])) begin
                    req[k]  = ($urandom_range(0, 99) < 60);
                    addr[k] = rand_addr();
                end
                we[k]    = !rst && ($urandom_range(0, 7) == 0);
                laddr[k] = 4'($urandom_range(0, 15));
                wdata[k] = $urandom;
            end
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                gexp = req[k] && !we[k] && !rst && (left[k] <= 0);
                check("rand_gnt", 64'(gnt[k]), 64'(gexp));
                check("rand_rvalid", 64'(rvalid[k]), 64'(left[k] == 0));
                check("rand_busy", 64'(busy[k]), 64'(left[k] >= 0));
                check("rand_rdata", 64'(rdata[k]), 64'(last_d[k]));
                check("rand_err", 64'(err[k]), 64'(last_e[k]));
                // Advance the model across the coming edge; reads see pre-write memory.
                if (rst) begin
                    left[k] = -1;
                    last_d[k] = 32'd0;
                    last_e[k] = 1'b0;
                end else begin
                    if (left[k] > 0) begin
                        left[k]--;
                        if (left[k] == 0) begin
                            r = resp_of(k, paddr[k]);
                            last_e[k] = r[32];
                            last_d[k] = r[31:0];
                        end
                    end else if (left[k] == 0) begin
                        left[k] = -1;
                    end
                    if (gexp) begin
                        paddr[k] = addr[k];
                        left[k] = ws_of(k);
                        if (left[k] == 0) begin
                            r = resp_of(k, addr[k]);
                            last_e[k] = r[32];
                            last_d[k] = r[31:0];
                        end
                    end
                end
                if (we[k]) exp_mem[k][laddr[k]] = wdata[k];
                gprev[k] = gexp;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 32, giving the data and address width.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 1024, giving the number of words (power of two).
REQ-003 The block SHALL have parameter WAIT_STATES, default 1, legal range 0..7, giving the extra response cycles.
REQ-004 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port instr_req_i, input, 1 bit: fetch request, held by the initiator until granted.
REQ-008 The block SHALL have port instr_addr_i, input, WORD_WIDTH bits: fetch byte address.
REQ-009 The block SHALL have port instr_gnt_o, output, 1 bit: request accepted this cycle.
REQ-010 The block SHALL have port instr_rvalid_o, output, 1 bit: instr_rdata_o/instr_err_o valid this cycle.
REQ-011 The block SHALL have port instr_rdata_o, output, WORD_WIDTH bits: fetched instruction.
REQ-012 The block SHALL have port instr_err_o, output, 1 bit: misaligned or out-of-range fetch, qualified by rvalid.
REQ-013 The block SHALL have port load_we_i, input, 1 bit: preload write enable.
REQ-014 The block SHALL have port load_addr_i, input, log2(MEM_DEPTH) bits: preload word index.
REQ-015 The block SHALL have port load_wdata_i, input, WORD_WIDTH bits: preload data.
REQ-016 The block SHALL have port busy_o, output, 1 bit: a transaction is pending (state != IDLE).

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP, plus a 3-bit wait counter.
REQ-018 instr_gnt_o SHALL be combinational: instr_req_i & !load_we_i & !rst & (state==IDLE | state==RESP).
REQ-019 On grant, the block SHALL latch instr_addr_i, load the counter with WAIT_STATES, and go to RESP if WAIT_STATES==0, else to WAIT.
REQ-020 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the cycle the counter equals 1.
REQ-021 In RESP, instr_rvalid_o SHALL be 1 for exactly one cycle; the FSM then goes to the grant target if granted that cycle, else to IDLE.
REQ-022 Latency SHALL be fixed: rvalid is asserted exactly WAIT_STATES+1 cycles after the grant cycle; only one transaction is outstanding.
REQ-023 With WAIT_STATES==0 and back-to-back requests, throughput SHALL be one word per cycle.
REQ-024 Word index SHALL be (latched_addr - BASE_ADDR) >> 2, using modulo 2^WORD_WIDTH subtraction.
REQ-025 If latched_addr[1:0] != 0 or the index >= MEM_DEPTH, the response SHALL be rdata=32'h0000_0013 (NOP) with instr_err_o=1; otherwise it SHALL be mem[index] with err=0.
REQ-026 instr_rdata_o and instr_err_o SHALL be registered, updated only on the edge entering RESP, and hold their value otherwise.
REQ-027 A load write SHALL take effect at the clock edge when load_we_i=1, in any state.
REQ-028 When a load write hits the word being read on the edge entering RESP, the read SHALL return the old data (read-before-write).
REQ-029 A load write SHALL not disturb a pending transaction; it SHALL only block new grants.
REQ-030 An address at BASE_ADDR+4*(MEM_DEPTH-1) SHALL be valid; BASE_ADDR+4*MEM_DEPTH SHALL error; addresses below BASE_ADDR wrap to a large index and SHALL error.

Reset
REQ-031 On a clock edge with rst=1, the block SHALL set state=IDLE, counter=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, busy_o=0; instr_gnt_o SHALL be 0 while rst=1.
REQ-032 Reset mid-transaction SHALL drop the pending fetch, with no rvalid issued afterwards.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-034 Preload mem[0..3]=11,22,33,44, WAIT_STATES=1, req held at addr 0x0 -> gnt in cycle N, rvalid in cycle N+2 with rdata=0x11, err=0.
REQ-035 WAIT_STATES=0, req held with addr 0x0,0x4,0x8 on consecutive cycles -> gnt every cycle, rvalid on three consecutive cycles with 0x11,0x22,0x33.
REQ-036 Req addr 0x2, then addr 4*MEM_DEPTH -> both return rdata=0x00000013 with err=1.
REQ-037 req=1 and load_we=1 in the same cycle -> gnt=0 that cycle; gnt next cycle once load_we=0; the write is visible on a subsequent fetch.
REQ-038 WAIT_STATES=3, rst pulsed one cycle after grant -> no rvalid ever issued, busy_o=0 after reset, mem still readable with preloaded values.
